// File: rtl/i2c_target_regs.sv
// I2C target with a DEPTH x 8 register file and an auto-incrementing register pointer.
// Every register write is also reported on a one-cycle strobe.
module i2c_target_regs #(
  parameter logic [6:0]  DEV_ADDR   = 7'h39,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     scl_i,
  input  logic                     sda_i,
  output logic                     sda_oe,
  output logic                     wr_en,
  output logic [$clog2(DEPTH)-1:0] wr_addr,
  output logic [7:0]               wr_data,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StReg, StRegAck, StWdata, StWdataAck, StRdata, StRdataAck
  } state_e;

  // Index 0 = SCL, index 1 = SDA. Idle bus level is high.
  logic [1:0]    meta_q, sync_q, filt_q, filt_prev_q;
  logic [CW-1:0] cnt_q [2];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q      <= '1;
      sync_q      <= '1;
      filt_q      <= '1;
      filt_prev_q <= '1;
      cnt_q[0]    <= '0;
      cnt_q[1]    <= '0;
    end else begin
      meta_q      <= {sda_i, scl_i};
      sync_q      <= meta_q;
      filt_prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_f    = filt_q[0];
  assign sda_f    = filt_q[1];
  assign scl_rise = scl_f & ~filt_prev_q[0];
  assign scl_fall = ~scl_f & filt_prev_q[0];
  assign start_ev = scl_f & filt_prev_q[1] & ~sda_f;
  assign stop_ev  = scl_f & ~filt_prev_q[1] & sda_f;

  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            rw_q, rw_d;
  logic            pend_q, pend_d;
  logic            sda_oe_q, sda_oe_d;
  logic            busy_q, busy_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [7:0]      mem_q [DEPTH];
  logic            mem_we;
  logic [7:0]      byte_in, rd_byte;

  assign byte_in = {shift_q[6:0], sda_f};
  assign rd_byte = mem_q[ptr_q];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    pend_d    = pend_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;
    if (start_ev) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      busy_d    = 1'b1;
      sda_oe_d  = 1'b0;
      pend_d    = 1'b0;
    end else if (stop_ev) begin
      state_d  = StIdle;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
      pend_d   = 1'b0;
    end else begin
      unique case (state_q)
        StAddr: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_in[7:1] == DEV_ADDR) begin
              state_d = StAddrAck;
              rw_d    = byte_in[0];
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end
        end
        // First SCL fall starts the ACK bit, the second one ends it.
        StAddrAck: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (!rw_q) begin
            state_d  = StReg;
            sda_oe_d = 1'b0;
          end else begin
            state_d   = StRdata;
            bit_cnt_d = '0;
            shift_d   = rd_byte;
            ptr_d     = ptr_q + 1'b1;
            sda_oe_d  = ~rd_byte[7];
          end
        end
        StReg: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ptr_d   = byte_in[AW-1:0];
            state_d = StRegAck;
          end
        end
        StRegAck, StWdataAck: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = StWdata;
          end
        end
        StWdata: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = byte_in;
            mem_we    = 1'b1;
            ptr_d     = ptr_q + 1'b1;
            state_d   = StWdataAck;
          end
        end
        StRdata: if (scl_fall) begin
          if (pend_q) begin
            // Byte loaded at the master ACK; its MSB goes out at the end of that ACK bit.
            pend_d   = 1'b0;
            sda_oe_d = ~shift_q[7];
          end else if (bit_cnt_q == 3'd7) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = StRdataAck;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {shift_q[6:0], 1'b0};
            sda_oe_d  = ~shift_q[6];
          end
        end
        StRdataAck: if (scl_rise) begin
          if (!sda_f) begin
            shift_d = rd_byte;
            ptr_d   = ptr_q + 1'b1;
            pend_d  = 1'b1;
            state_d = StRdata;
          end else begin
            state_d = StIdle;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      pend_q    <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      pend_q    <= pend_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      if (mem_we) mem_q[ptr_q] <= byte_in;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
